ascon_round_fsm: RTL and testbench
==================================

# ascon_round_fsm

Permutation round sequencer for the ASCON core. Accepts p12/p6 permutation requests over a start/ready handshake, drives the 4-bit round counter (enable, load-0, load-6), reads back the round index, emits the per-round constant and datapath state-register enable, and signals completion with a one-cycle done pulse. Sits between the mode-level ASCON controller and the permutation datapath plus round counter.

## Interface
- No parameters.
- clock_i  in  1  system clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  permutation request, accepted when start_i & ready_o
- mode_i  in  1  0 = p12 (rounds 0..11), 1 = p6 (rounds 6..11); sampled only at accept
- counter_i  in  4  current round index from the round counter
- ready_o  out  1  block idle, can accept a request
- enable_cpt_o  out  1  round counter enable
- init_a_o  out  1  round counter load 0 (p12)
- init_b_o  out  1  round counter load 6 (p6)
- en_state_o  out  1  permutation state-register enable, one round per cycle
- rc_o  out  8  round constant for current round
- done_o  out  1  one-cycle pulse, permutation finished
- err_o  out  1  sequencing error flag (see Configuration)

## Operation
- States: IDLE, LOAD, RUN, DONE. Reset state IDLE.
- IDLE: ready_o=1. On start_i=1: latch mode_i, go LOAD. Otherwise stay.
- LOAD (1 cycle): enable_cpt_o=1; init_a_o=1 if p12, init_b_o=1 if p6 (never both). Go RUN.
- RUN: en_state_o=1, enable_cpt_o=1, init_a_o=init_b_o=0. rc_o = {4'hF - counter_i, counter_i} (p12 round 0 -> 0xF0, round 6 -> 0x96, round 11 -> 0x4B). When counter_i == 11: last round, go DONE.
- DONE (1 cycle): done_o=1, all other outputs 0 except err_o. Go IDLE.
- rc_o = 0 outside RUN. ready_o=1 only in IDLE; start_i ignored in LOAD/RUN/DONE.
- Arithmetic: 4-bit subtraction 4'hF - counter_i, no wrap possible for legal 0..11.
- counter_i values 12..15 in RUN: without check, FSM stays in RUN (counter wraps 15->0 externally and continues to 11); with check, see Configuration.

## Timing
- Reset: ready_o=1 after reset released; all other outputs 0 during and after reset, err_o=0. Reset in any state returns to IDLE next edge, aborting the permutation; no done_o.
- Request accepted at edge T (start_i & ready_o). LOAD in cycle T+1, counter holds 0/6 from T+2.
- RUN cycles: T+2..T+13 (p12, 12 cycles), T+2..T+7 (p6, 6 cycles).
- done_o high in cycle T+14 (p12) / T+8 (p6). ready_o high next cycle; earliest next accept one cycle after done_o.
- Back-to-back: start_i held high continuously produces a request every 15 cycles (p12) / 9 cycles (p6).

## Configuration
- Macro ASCON_ROUND_CHECK_EN.
- Defined: in first RUN cycle counter_i must equal 0 (p12) or 6 (p6); in every RUN cycle counter_i must be <= 11. Violation -> err_o set (sticky), FSM to IDLE next edge, no done_o. err_o cleared by reset or by next accepted start.
- Undefined: no checks, err_o tied 0, FSM follows Operation rules only.

## Test plan
- Reset then p12 request (mode_i=0) with counter model: init_a_o pulse in LOAD, 12 en_state_o cycles, rc_o sequence 0xF0,0xE1,...,0x4B, done_o at T+14.
- p6 request (mode_i=1): init_b_o pulse, 6 RUN cycles, rc_o 0x96,0x87,0x78,0x69,0x5A,0x4B, done_o at T+8.
- start_i held high across p12 then p6 (mode_i toggled mid-run): mode change ignored until accept, second accept one cycle after done_o.
- reset_i asserted in 5th RUN cycle: next cycle all outputs 0, ready_o=1 after release, no done_o.
- ASCON_ROUND_CHECK_EN: counter model forced to 3 at first p6 RUN cycle -> err_o=1, FSM IDLE, no done_o; next accepted start clears err_o.
- ASCON_ROUND_CHECK_EN undefined: same stimulus -> err_o stays 0, RUN continues until counter_i reaches 11.

Source files
------------

// File: rtl/ascon_round_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ascon_round_fsm                                              |
// | Description : Permutation round sequencer for the ASCON core. Accepts      |
// |               p12/p6 requests over a start/ready handshake, steers the     |
// |               external 4-bit round counter (enable, load 0, load 6),       |
// |               produces the per-round constant and the permutation          |
// |               state-register enable, and pulses done_o on completion.      |
// | Optional    : `define ASCON_ROUND_CHECK_EN adds round-counter sequencing   |
// |               checks with a sticky err_o flag.                             |
// | Ports       : clock_i      system clock (rising edge)                      |
// |               reset_i      synchronous active-high reset                   |
// |               start_i      request, accepted when start_i & ready_o        |
// |               mode_i       0 = p12 (rounds 0..11), 1 = p6 (rounds 6..11)   |
// |               counter_i    current round index from the round counter      |
// |               ready_o      idle, can accept a request                      |
// |               enable_cpt_o round counter enable                            |
// |               init_a_o     round counter load 0 (p12)                      |
// |               init_b_o     round counter load 6 (p6)                       |
// |               en_state_o   permutation state-register enable               |
// |               rc_o         round constant for current round                |
// |               done_o       one-cycle completion pulse                      |
// |               err_o        sequencing error flag (sticky)                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+

module ascon_round_fsm (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic [3:0] counter_i,
  output logic       ready_o,
  output logic       enable_cpt_o,
  output logic       init_a_o,
  output logic       init_b_o,
  output logic       en_state_o,
  output logic [7:0] rc_o,
  output logic       done_o,
  output logic       err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] C_LAST_ROUND = 4'd11;
  localparam logic [3:0] C_P12_FIRST  = 4'd0;
  localparam logic [3:0] C_P6_FIRST   = 4'd6;

  state_t     r_state;
  state_t     w_state_next;
  logic       r_mode;        // latched request mode: 1 = p6
  logic       w_accept;
  logic       w_violation;
  logic [3:0] w_rc_hi;

  assign w_accept = start_i & (r_state == S_IDLE);

  // Upper nibble of the round constant; legal rounds 0..11 never wrap.
  assign w_rc_hi = 4'hF - counter_i;

`ifdef ASCON_ROUND_CHECK_EN
  logic       r_first;       // high during the first RUN cycle
  logic       r_err;
  logic [3:0] w_first_round;

  assign w_first_round = r_mode ? C_P6_FIRST : C_P12_FIRST;

  // The counter must start where LOAD put it and never leave the 0..11 range.
  assign w_violation = (r_state == S_RUN) &&
                       ((r_first && (counter_i != w_first_round)) ||
                        (counter_i > C_LAST_ROUND));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_first <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_first <= (r_state == S_LOAD);
      // A fresh request clears a previous error; it can never coincide
      // with a new violation since accept only happens in IDLE.
      if (w_accept) begin
        r_err <= 1'b0;
      end else if (w_violation) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_o = r_err;
`else
  assign w_violation = 1'b0;
  assign err_o       = 1'b0;
`endif

  // State and mode registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_mode <= mode_i;
      end
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    enable_cpt_o = 1'b0;
    init_a_o     = 1'b0;
    init_b_o     = 1'b0;
    en_state_o   = 1'b0;
    rc_o         = 8'h00;
    done_o       = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (start_i) begin
          w_state_next = S_LOAD;
        end
      end

      S_LOAD: begin
        enable_cpt_o = 1'b1;
        init_a_o     = ~r_mode;
        init_b_o     = r_mode;
        w_state_next = S_RUN;
      end

      S_RUN: begin
        enable_cpt_o = 1'b1;
        en_state_o   = 1'b1;
        rc_o         = {w_rc_hi, counter_i};
        // Out-of-range counts without checking simply keep running until
        // the external counter wraps back around to the last round.
        if (w_violation) begin
          w_state_next = S_IDLE;
        end else if (counter_i == C_LAST_ROUND) begin
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        done_o       = 1'b1;
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ascon_round_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ascon_round_fsm                                           |
// | Description : Directed self-checking bench for ascon_round_fsm with a      |
// |               behavioural round counter model.                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+

module tb_ascon_round_fsm;

  logic       clock_i = 1'b0;
  logic       reset_i;
  logic       start_i;
  logic       mode_i;
  logic [3:0] counter_i;
  logic       ready_o;
  logic       enable_cpt_o;
  logic       init_a_o;
  logic       init_b_o;
  logic       en_state_o;
  logic [7:0] rc_o;
  logic       done_o;
  logic       err_o;

  int vectors     = 0;
  int miscompares = 0;

  // Corrupts the p6 load value to 3 when set.
  logic load3 = 1'b0;

  // Expected {ready, enable_cpt, init_a, init_b, en_state, done, err}
  localparam logic [6:0] E_IDLE   = 7'b1000000;
  localparam logic [6:0] E_LOAD_A = 7'b0110000;
  localparam logic [6:0] E_LOAD_B = 7'b0101000;
  localparam logic [6:0] E_RUN    = 7'b0100100;
  localparam logic [6:0] E_DONE   = 7'b0000010;
  localparam logic [6:0] E_ERR    = 7'b1000001;

  // Round constants for rounds 0..11, worked out by hand.
  logic [7:0] rc_tab [12] = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
                              8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};

  wire [14:0] outs = {ready_o, enable_cpt_o, init_a_o, init_b_o,
                      en_state_o, done_o, err_o, rc_o};

  ascon_round_fsm dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .counter_i    (counter_i),
    .ready_o      (ready_o),
    .enable_cpt_o (enable_cpt_o),
    .init_a_o     (init_a_o),
    .init_b_o     (init_b_o),
    .en_state_o   (en_state_o),
    .rc_o         (rc_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clock_i = ~clock_i;

  // Round counter model.
  always @(posedge clock_i) begin
    if (reset_i) begin
      counter_i <= 4'd0;
    end else if (enable_cpt_o) begin
      if (init_a_o)      counter_i <= 4'd0;
      else if (init_b_o) counter_i <= load3 ? 4'd3 : 4'd6;
      else               counter_i <= counter_i + 4'd1;
    end
  end

  task automatic tick;
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    start_i = 1'b0;
    mode_i  = 1'b0;

    // Reset: everything except ready low while reset is held.
    tick; tick;
    chk("reset_outs", outs & 15'h3FFF, 15'h0000);
    reset_i = 1'b0;
    tick;
    chk("reset_idle", outs, {E_IDLE, 8'h00});

    // p12 request.
    start_i = 1'b1; mode_i = 1'b0;
    tick;
    start_i = 1'b0;
    chk("p12_load", outs, {E_LOAD_A, 8'h00});
    for (int i = 0; i < 12; i++) begin
      tick;
      chk("p12_run", outs, {E_RUN, rc_tab[i]});
    end
    tick; chk("p12_done", outs, {E_DONE, 8'h00});
    tick; chk("p12_idle", outs, {E_IDLE, 8'h00});

    // p6 request; mode change after accept must not matter.
    start_i = 1'b1; mode_i = 1'b1;
    tick;
    start_i = 1'b0; mode_i = 1'b0;
    chk("p6_load", outs, {E_LOAD_B, 8'h00});
    for (int i = 6; i < 12; i++) begin
      tick;
      chk("p6_run", outs, {E_RUN, rc_tab[i]});
    end
    tick; chk("p6_done", outs, {E_DONE, 8'h00});
    tick; chk("p6_idle", outs, {E_IDLE, 8'h00});

    // Back-to-back with start held, mode toggled mid-run.
    start_i = 1'b1; mode_i = 1'b0;
    tick;
    chk("b2b_load_a", outs, {E_LOAD_A, 8'h00});
    for (int i = 0; i < 12; i++) begin
      tick;
      if (i == 3) mode_i = 1'b1;
      chk("b2b_run12", outs, {E_RUN, rc_tab[i]});
    end
    tick; chk("b2b_done12", outs, {E_DONE, 8'h00});
    tick; chk("b2b_idle", outs, {E_IDLE, 8'h00});
    tick; chk("b2b_load_b", outs, {E_LOAD_B, 8'h00});
    start_i = 1'b0;
    for (int i = 6; i < 12; i++) begin
      tick;
      chk("b2b_run6", outs, {E_RUN, rc_tab[i]});
    end
    tick; chk("b2b_done6", outs, {E_DONE, 8'h00});
    tick; chk("b2b_idle2", outs, {E_IDLE, 8'h00});

    // Reset in the 5th RUN cycle aborts without done.
    start_i = 1'b1; mode_i = 1'b0;
    tick;
    start_i = 1'b0;
    chk("abort_load", outs, {E_LOAD_A, 8'h00});
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("abort_run", outs, {E_RUN, rc_tab[i]});
    end
    reset_i = 1'b1;
    tick;
    chk("abort_reset", outs & 15'h3FFF, 15'h0000);
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_idle", outs, {E_IDLE, 8'h00});
    end

    // p6 with counter loaded to 3 instead of 6.
    load3 = 1'b1;
    start_i = 1'b1; mode_i = 1'b1;
    tick;
    start_i = 1'b0;
    chk("bad_load", outs, {E_LOAD_B, 8'h00});
    tick;
    chk("bad_run_first", outs, {E_RUN, 8'hC3});
`ifdef ASCON_ROUND_CHECK_EN
    tick; chk("err_idle", outs, {E_ERR, 8'h00});
    tick; chk("err_sticky", outs, {E_ERR, 8'h00});
    load3 = 1'b0;
    start_i = 1'b1; mode_i = 1'b1;
    tick;
    start_i = 1'b0;
    chk("err_clr_load", outs, {E_LOAD_B, 8'h00});
    for (int i = 6; i < 12; i++) begin
      tick;
      chk("err_clr_run", outs, {E_RUN, rc_tab[i]});
    end
    tick; chk("err_clr_done", outs, {E_DONE, 8'h00});
    tick; chk("err_clr_idle", outs, {E_IDLE, 8'h00});
`else
    for (int i = 4; i < 12; i++) begin
      tick;
      chk("nochk_run", outs, {E_RUN, rc_tab[i]});
    end
    tick; chk("nochk_done", outs, {E_DONE, 8'h00});
    tick; chk("nochk_idle", outs, {E_IDLE, 8'h00});
    load3 = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
